// File: rtl/sudoku_timer_pkg.sv
// Shared constants for the Sudoku elapsed-time controller: state encoding,
// BCD digit geometry and the mm:ss limits.
package sudoku_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } timer_state_e;

  localparam int unsigned BCD_W               = 4;
  localparam int unsigned BCD_DIGIT_MAX       = 9;
  localparam int unsigned SEC_TENS_MAX        = 5;
  localparam int unsigned MIN_MAX             = 99;
  localparam int unsigned DEFAULT_TICK_PERIOD = 50_000_000;

  // Rollover digit for each position of mm:ss, least significant first.
  function automatic int unsigned digit_limit(int unsigned idx);
    case (idx)
      0:       return BCD_DIGIT_MAX;
      1:       return SEC_TENS_MAX;
      2:       return MIN_MAX % 10;
      default: return MIN_MAX / 10;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the elapsed-time display. Counts 0..MAX_DIGIT and flags a
// carry whenever an increment arrives while the digit sits at MAX_DIGIT.
module bcd_digit_counter
  import sudoku_timer_pkg::*;
#(
  parameter int unsigned MAX_DIGIT = BCD_DIGIT_MAX
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             hold_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  localparam logic [BCD_W-1:0] LAST = BCD_W'(MAX_DIGIT);

  logic [BCD_W-1:0] digit_q, digit_d;

  // Carry is reported even when held so the top level can see an overflow coming.
  assign carry_o = inc_i && (digit_q == LAST);
  assign digit_o = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (inc_i && !hold_i) begin
      digit_d = carry_o ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Elapsed-time controller: a prescaler and command FSM feeding a chained BCD
// mm:ss counter that saturates at 99:59.
module game_timer_ctrl
  import sudoku_timer_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = DEFAULT_TICK_PERIOD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [1:0] state,
  output logic       sec_tick,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       done
);

  localparam int unsigned      PRE_W    = $clog2(TICK_PERIOD);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_PERIOD - 1);
  localparam int               N_DIGITS = 4;

  timer_state_e     state_q;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_q, done_q;
  logic             go_cmd, second_due, advance, time_clr, saturate;
  logic [N_DIGITS:0] carry;
  logic [BCD_W-1:0] digit [N_DIGITS];

  assign go_cmd     = start && !pause && !stop;
  assign presc_d    = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
  // The tick is registered, so the second is decided one cycle before the
  // prescaler shows its last value; that keeps ticks TICK_PERIOD apart.
  assign second_due = (presc_d == PRE_LAST);
  assign advance    = (state_q == ST_RUNNING) && !stop && second_due;
  assign time_clr   = (state_q == ST_IDLE) && go_cmd;
  assign carry[0]   = advance;
  assign saturate   = carry[N_DIGITS];

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    bcd_digit_counter #(
      .MAX_DIGIT(digit_limit(gi))
    ) u_digit (
      .clock_i(clock),
      .reset_i(reset),
      .clr_i  (time_clr),
      .inc_i  (carry[gi]),
      .hold_i (saturate),
      .digit_o(digit[gi]),
      .carry_o(carry[gi+1])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (go_cmd) begin
            state_q <= ST_RUNNING;
            presc_q <= '0;
          end
        end
        ST_RUNNING: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else begin
            // A pause still counts its own cycle, so pause/resume loses no time.
            presc_q <= presc_d;
            tick_q  <= second_due;
            if (saturate) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (pause) begin
              state_q <= ST_PAUSED;
            end
          end
        end
        ST_PAUSED: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (go_cmd) begin
            state_q <= ST_RUNNING;
          end
        end
        ST_DONE: begin
          if (stop) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign state    = state_q;
  assign sec_tick = tick_q;
  assign sec_bcd  = {digit[1], digit[0]};
  assign min_bcd  = {digit[3], digit[2]};
  assign done     = done_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl with TICK_PERIOD=4: a per-cycle vector table,
// scoreboarded corner-case sequences and long tick-counting runs.
module tb_game_timer_ctrl;

  localparam int unsigned TP = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop  = 1'b0;
  logic [1:0] state;
  logic       sec_tick;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       done;

  typedef struct {
    logic [1:0] st;
    logic       tick;
    logic [7:0] sec;
    logic [7:0] mins;
    logic       dn;
    string      tag;
  } exp_t;

  typedef struct {
    logic       go;
    logic       hold;
    logic       halt;
    logic [1:0] st;
    logic       tick;
    logic [7:0] sec;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[19];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_secs = 0;
  int   cyc;

  game_timer_ctrl #(.TICK_PERIOD(TP)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .stop    (stop),
    .state   (state),
    .sec_tick(sec_tick),
    .sec_bcd (sec_bcd),
    .min_bcd (min_bcd),
    .done    (done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic exp_t mk(logic [1:0] st, logic tick, logic [7:0] sec, logic [7:0] mins,
                              logic dn, string tag);
    exp_t e;
    e.st = st; e.tick = tick; e.sec = sec; e.mins = mins; e.dn = dn; e.tag = tag;
    return e;
  endfunction

  function automatic vec_t v(logic go, logic hold, logic halt, logic [1:0] st, logic tick,
                             logic [7:0] sec);
    vec_t r;
    r.go = go; r.hold = hold; r.halt = halt; r.st = st; r.tick = tick; r.sec = sec;
    return r;
  endfunction

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expectation, expected one queued");
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, ".state"}, 32'(state), 32'(e.st));
    check({e.tag, ".tick"},  32'(sec_tick), 32'(e.tick));
    check({e.tag, ".sec"},   32'(sec_bcd), 32'(e.sec));
    check({e.tag, ".min"},   32'(min_bcd), 32'(e.mins));
    check({e.tag, ".done"},  32'(done), 32'(e.dn));
    $display("%-12s state=%0d tick=%0b time=%02h:%02h done=%0b",
             e.tag, state, sec_tick, min_bcd, sec_bcd, done);
  endtask

  // Drive one cycle of commands, queue what the next cycle must show, then compare.
  task automatic drive(input logic rst, input logic go, input logic hold, input logic halt,
                       input exp_t e);
    reset = rst; start = go; pause = hold; stop = halt;
    sb_q.push_back(e);
    step();
    reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    compare_pop();
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (sec_tick !== 1'b1 && cycles < 4 * TP);
    if (sec_tick !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: got no sec_tick in %0d cycles, expected one every %0d",
               cycles, TP);
      finish_test();
    end
  endtask

  // Let the timer run, checking cadence and BCD value of every tick up to target seconds.
  task automatic run_to(int target, bit first_timed);
    int  c;
    bit  timed;
    timed = first_timed;
    while (exp_secs < target) begin
      wait_tick(c);
      exp_secs++;
      if (timed) check("tick_interval", 32'(c), 32'(TP));
      timed = 1'b1;
      check("tick_sec",   32'(sec_bcd), 32'(to_bcd(exp_secs % 60)));
      check("tick_min",   32'(min_bcd), 32'(to_bcd(exp_secs / 60)));
      check("tick_state", 32'(state), 32'(S_RUN));
      check("tick_done",  32'(done), 32'(1'b0));
    end
  endtask

  initial begin
    // start at cycle 0: ticks at cycles 4, 8, 12; stop on the cycle that would produce tick 4
    tbl[0]  = v(1, 0, 0, S_RUN,  0, 8'h00);
    tbl[1]  = v(0, 0, 0, S_RUN,  0, 8'h00);
    tbl[2]  = v(0, 0, 0, S_RUN,  0, 8'h00);
    tbl[3]  = v(0, 0, 0, S_RUN,  1, 8'h01);
    tbl[4]  = v(0, 0, 0, S_RUN,  0, 8'h01);
    tbl[5]  = v(0, 0, 0, S_RUN,  0, 8'h01);
    tbl[6]  = v(0, 0, 0, S_RUN,  0, 8'h01);
    tbl[7]  = v(0, 0, 0, S_RUN,  1, 8'h02);
    tbl[8]  = v(0, 0, 0, S_RUN,  0, 8'h02);
    tbl[9]  = v(0, 0, 0, S_RUN,  0, 8'h02);
    tbl[10] = v(0, 0, 0, S_RUN,  0, 8'h02);
    tbl[11] = v(0, 0, 0, S_RUN,  1, 8'h03);
    tbl[12] = v(0, 0, 0, S_RUN,  0, 8'h03);
    tbl[13] = v(0, 0, 0, S_RUN,  0, 8'h03);
    tbl[14] = v(0, 0, 0, S_RUN,  0, 8'h03);
    tbl[15] = v(0, 0, 1, S_IDLE, 0, 8'h03);
    tbl[16] = v(0, 0, 0, S_IDLE, 0, 8'h03);
    tbl[17] = v(0, 1, 0, S_IDLE, 0, 8'h03);
    tbl[18] = v(0, 0, 1, S_IDLE, 0, 8'h03);

    drive(1, 0, 0, 0, mk(S_IDLE, 0, 8'h00, 8'h00, 0, "reset0"));
    drive(1, 1, 0, 0, mk(S_IDLE, 0, 8'h00, 8'h00, 0, "reset1"));
    drive(0, 0, 0, 0, mk(S_IDLE, 0, 8'h00, 8'h00, 0, "idle"));

    for (int i = 0; i < 19; i++) begin
      drive(0, tbl[i].go, tbl[i].hold, tbl[i].halt,
            mk(tbl[i].st, tbl[i].tick, tbl[i].sec, 8'h00, 0, $sformatf("vec%0d", i)));
    end

    // Pause two cycles after a tick, hold ten cycles, resume.
    drive(0, 1, 0, 0, mk(S_RUN, 0, 8'h00, 8'h00, 0, "restart"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h00, 8'h00, 0, "p_run1"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h00, 8'h00, 0, "p_run2"));
    drive(0, 0, 0, 0, mk(S_RUN, 1, 8'h01, 8'h00, 0, "p_tick1"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h01, 8'h00, 0, "p_run3"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h01, 8'h00, 0, "p_run4"));
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, mk(S_PAUSE, 0, 8'h01, 8'h00, 0, $sformatf("p_hold%0d", i)));
    end
    drive(0, 1, 0, 0, mk(S_RUN, 0, 8'h01, 8'h00, 0, "p_resume"));
    drive(0, 0, 0, 0, mk(S_RUN, 1, 8'h02, 8'h00, 0, "p_tick2"));

    // Pause on the cycle that completes a second: tick and update still happen.
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h02, 8'h00, 0, "pw_run1"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h02, 8'h00, 0, "pw_run2"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h02, 8'h00, 0, "pw_run3"));
    drive(0, 0, 1, 0, mk(S_PAUSE, 1, 8'h03, 8'h00, 0, "pw_tick"));
    drive(0, 0, 0, 0, mk(S_PAUSE, 0, 8'h03, 8'h00, 0, "pw_held"));
    drive(0, 1, 0, 0, mk(S_RUN, 0, 8'h03, 8'h00, 0, "pw_resume"));

    // Seconds rollover into minutes, then reset mid-second at 01:07.
    exp_secs = 3;
    run_to(59, 1'b0);
    run_to(60, 1'b1);
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h00, 8'h01, 0, "post_carry"));
    run_to(67, 1'b0);
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h07, 8'h01, 0, "r_pre0"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h07, 8'h01, 0, "r_pre1"));
    drive(0, 0, 0, 0, mk(S_RUN, 0, 8'h07, 8'h01, 0, "r_pre2"));
    drive(1, 0, 0, 0, mk(S_IDLE, 0, 8'h00, 8'h00, 0, "rst_mid"));
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, mk(S_IDLE, 0, 8'h00, 8'h00, 0, $sformatf("rst_quiet%0d", i)));
    end

    // Full run to saturation at 99:59.
    drive(0, 1, 0, 0, mk(S_RUN, 0, 8'h00, 8'h00, 0, "sat_start"));
    exp_secs = 0;
    run_to(5998, 1'b0);
    run_to(5999, 1'b1);
    wait_tick(cyc);
    check("sat_interval", 32'(cyc), 32'(TP));
    check("sat_sec",   32'(sec_bcd), 32'h59);
    check("sat_min",   32'(min_bcd), 32'h99);
    check("sat_state", 32'(state), 32'(S_DONE));
    check("sat_done",  32'(done), 32'(1'b1));
    $display("saturate     state=%0d tick=%0b time=%02h:%02h done=%0b",
             state, sec_tick, min_bcd, sec_bcd, done);
    drive(0, 0, 0, 0, mk(S_DONE, 0, 8'h59, 8'h99, 1, "done_hold"));
    drive(0, 1, 0, 0, mk(S_DONE, 0, 8'h59, 8'h99, 1, "done_start"));
    drive(0, 0, 1, 0, mk(S_DONE, 0, 8'h59, 8'h99, 1, "done_pause"));
    drive(0, 0, 0, 0, mk(S_DONE, 0, 8'h59, 8'h99, 1, "done_hold2"));
    drive(0, 0, 0, 1, mk(S_IDLE, 0, 8'h59, 8'h99, 0, "done_stop"));
    drive(0, 1, 0, 0, mk(S_RUN, 0, 8'h00, 8'h00, 0, "final_start"));

    finish_test();
  end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Elapsed-time controller for the Sudoku game. It sequences a free-running prescaler into a one-cycle-per-second tick and accumulates play time as BCD minutes:seconds. It exposes start/pause/stop control from the game FSM and saturates at 99:59 with a done flag. It sits between the game controller (commands) and the display driver (BCD digits, tick).

## Interface
- `TICK_PERIOD`, default 50000000: clock cycles per elapsed second; legal range 2..2^32-1.
- `clock`  in  1  system clock, 50 MHz nominal.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `start`  in  1  level command, sampled every cycle: begin or resume timing.
- `pause`  in  1  level command: freeze timing.
- `stop`  in  1  level command: abort to idle.
- `state`  out  2  0 IDLE, 1 RUNNING, 2 PAUSED, 3 DONE.
- `sec_tick`  out  1  one-cycle pulse when seconds advance.
- `sec_bcd`  out  8  seconds, two BCD digits, 00..59.
- `min_bcd`  out  8  minutes, two BCD digits, 00..99.
- `done`  out  1  high while in DONE.

## Operation
- All outputs are registered. Reset drives `state`=IDLE, `sec_tick`=0, `sec_bcd`=0x00, `min_bcd`=0x00, `done`=0, and prescaler=0.
- Command priority is stop > pause > start. Lower-priority commands in the same cycle are ignored.
- IDLE:
  - `start` clears the time to 00:00, clears the prescaler and goes to RUNNING.
  - `pause` and `stop` have no effect.
- RUNNING:
  - The prescaler increments every cycle.
  - At TICK_PERIOD-1 the prescaler wraps to 0 and the seconds field advances.
  - `pause` goes to PAUSED and holds the prescaler value.
  - `stop` goes to IDLE and holds the displayed time.
- PAUSED:
  - The prescaler and time are frozen.
  - `start` returns to RUNNING, continuing from the frozen prescaler value.
  - `stop` goes to IDLE.
- DONE:
  - The time holds at 99:59.
  - Only `stop` leaves DONE, to IDLE. `start` is ignored.
- Time arithmetic:
  - Seconds ones digit counts 0..9 and carries into the tens digit.
  - Seconds tens digit counts 0..5. At 59 the seconds wrap to 00 and carry into minutes.
  - Minutes count 00..99 in BCD.
  - A tick at 99:59 does not wrap. The time stays 99:59, `sec_tick` still pulses, and the state goes to DONE.
- No binary-coded or non-BCD value ever appears on `sec_bcd` or `min_bcd`.

## Timing
- Start latency: `start` high in cycle N gives `state`=RUNNING in cycle N+1.
- Tick timing:
  - The first `sec_tick` occurs in cycle N+TICK_PERIOD, in the same cycle the updated time appears.
  - Later ticks follow every TICK_PERIOD cycles of RUNNING.
- `sec_tick` is high for exactly one cycle per second advanced. It is never high outside the cycle after a RUNNING-state wrap.
- Pause/resume conserves cycles: the total RUNNING cycles between ticks equals TICK_PERIOD exactly.
- Prescaler wrap and `pause` in the same cycle: the tick and time update still occur, then the state becomes PAUSED.
- Prescaler wrap and `stop` in the same cycle: `stop` wins. There is no tick, and the time holds its pre-wrap value.
- Reset mid-operation (any state, any prescaler value): all outputs return to reset values on the next edge. No tick is emitted.
- `done` and the DONE state both assert in the same cycle as the saturating `sec_tick`.

## Structure
- Shared package `sudoku_timer_pkg` holds:
  - the state encoding constants (IDLE/RUNNING/PAUSED/DONE);
  - the BCD digit width (4);
  - the limits SEC_TENS_MAX=5 and MIN_MAX=99;
  - the default TICK_PERIOD.
- Sub-module `bcd_digit_counter`, parameter MAX_DIGIT:
  - one BCD digit with enable, clear and carry-out;
  - instantiated four times (sec ones/tens, min ones/tens), chained by carry.
- The prescaler and FSM live in `game_timer_ctrl`.
- Width of the prescaler is $clog2(TICK_PERIOD).

## Test plan
All scenarios use TICK_PERIOD=4.
- Reset then `start` pulse at cycle 0:
  - `state`=RUNNING at cycle 1;
  - `sec_tick` at cycles 4, 8 and 12;
  - `sec_bcd` reads 0x01, 0x02 and 0x03 at those cycles.
- Run to 00:59, then one more tick → `sec_bcd`=0x00, `min_bcd`=0x01, single `sec_tick`.
- `pause` 2 cycles after a tick, hold for 10 cycles, then `start` → next tick exactly 2 RUNNING cycles after resume; time is unchanged during the pause.
- Preload to 99:58, then two ticks:
  - the time reads 99:59 with `done`=1 and `state`=DONE;
  - a later `start` is ignored;
  - `stop` → IDLE with 99:59 held.
- `stop` asserted exactly on the wrap cycle at 00:03 → IDLE, `sec_bcd`=0x03, no `sec_tick`.
- Assert `reset` while RUNNING at 01:07 with prescaler=2 → all outputs zero and IDLE next cycle; no tick for the following 8 cycles.
